// File: rtl/pipeline_ctrl_pkg.sv
// ============================================================================
// Module : pipeline_ctrl_pkg
// Brief  : Shared types and defaults for the pipeline control unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pipeline_ctrl_pkg;

  localparam int DEFAULT_CNT_W = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } ctrl_state_e;

endpackage

`default_nettype wire

// File: rtl/pipeline_control_unit_perf_counter.sv
// ============================================================================
// Module : perf_counter
// Brief  : Enable-gated counter that sticks at all-ones instead of wrapping.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module perf_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (en && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipeline_control_unit.sv
// ============================================================================
// Module : pipeline_control_unit
// Brief  : Hazard stall/flush control plus debug halt/step FSM.
//          Optional counters enabled by macro PIPE_PERF_COUNTERS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipeline_control_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_hazard_i,
  input  logic             branch_taken_i,
  input  logic             mem_busy_i,
  input  logic             halt_req_i,
  input  logic             step_req_i,
  input  logic             resume_req_i,
  input  logic             flush_req_i,
  output logic             pc_write_en_o,
  output logic             if_id_write_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             global_stall_o,
  output logic             global_flush_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
);

  ctrl_state_e r_state;
  logic        r_halt_pending;
  logic        r_halted;
  logic        r_gflush;
  logic        w_stall;

  assign w_stall = (r_state == HALTED) || mem_busy_i;

  // A stalled pipeline must not drop instructions, so local flushes wait.
  always_comb begin
    pc_write_en_o    = 1'b1;
    if_id_write_en_o = 1'b1;
    if_id_flush_o    = 1'b0;
    id_ex_flush_o    = 1'b0;
    if (w_stall) begin
      pc_write_en_o    = 1'b0;
      if_id_write_en_o = 1'b0;
    end else if (branch_taken_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (load_use_hazard_i) begin
      pc_write_en_o    = 1'b0;
      if_id_write_en_o = 1'b0;
      id_ex_flush_o    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= RUN;
      r_halt_pending <= 1'b0;
      r_halted       <= 1'b0;
      r_gflush       <= 1'b0;
    end else begin
      r_gflush <= 1'b0;
      case (r_state)
        RUN: begin
          if (halt_req_i || r_halt_pending) begin
            if (!mem_busy_i) begin
              r_state        <= HALTED;
              r_halted       <= 1'b1;
              r_halt_pending <= 1'b0;
            end else begin
              r_halt_pending <= 1'b1;
            end
          end
        end
        HALTED: begin
          r_gflush <= flush_req_i;
          if (resume_req_i) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
          end else if (step_req_i) begin
            r_state  <= STEP;
            r_halted <= 1'b0;
          end
        end
        STEP: begin
          if (!mem_busy_i) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
          end
        end
        default: begin
          r_state  <= RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign global_stall_o = w_stall;
  assign global_flush_o = r_gflush;
  assign halted_o       = r_halted;

`ifdef PIPE_PERF_COUNTERS_EN
  logic w_stall_inc;
  logic w_flush_inc;

  // A load-use bubble costs a cycle just like a freeze does.
  assign w_stall_inc = w_stall || (!branch_taken_i && load_use_hazard_i);
  assign w_flush_inc = if_id_flush_o || id_ex_flush_o || r_gflush;

  perf_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_stall_inc),
    .count (stall_cycles_o)
  );

  perf_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_flush_inc),
    .count (flush_count_o)
  );
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_control_unit.sv
// ============================================================================
// Module : tb_pipeline_control_unit
// Brief  : Scoreboard bench for pipeline_control_unit (PIPE_PERF_COUNTERS_EN aware).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_control_unit;

  localparam int CW = 4;
`ifdef PIPE_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output vector order: {pc_we, ifid_we, ifid_fl, idex_fl, gstall, gflush, halted}
  localparam logic [6:0] E_RUN   = 7'b1100000;
  localparam logic [6:0] E_LU    = 7'b0001000;
  localparam logic [6:0] E_BR    = 7'b1111000;
  localparam logic [6:0] E_BUSY  = 7'b0000100;
  localparam logic [6:0] E_HALT  = 7'b0000101;
  localparam logic [6:0] E_GFL   = 7'b0000111;
  localparam logic [6:0] M_ALL   = 7'b1111111;
  localparam logic [6:0] M_STALL = 7'b0011111;

  // Input vector order: {lu, br, busy, halt, step, resume, flush}
  localparam logic [6:0] I_NONE = 7'b0000000;
  localparam logic [6:0] I_LU   = 7'b1000000;
  localparam logic [6:0] I_BR   = 7'b0100000;
  localparam logic [6:0] I_BUSY = 7'b0010000;
  localparam logic [6:0] I_HALT = 7'b0001000;
  localparam logic [6:0] I_STEP = 7'b0000100;
  localparam logic [6:0] I_RES  = 7'b0000010;
  localparam logic [6:0] I_FL   = 7'b0000001;

  typedef struct {
    logic [6:0]    exp;
    logic [6:0]    mask;
    bit            chk_cnt;
    logic [CW-1:0] exp_stall;
    logic [CW-1:0] exp_flush;
    string         name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lu = 1'b0, br = 1'b0, busy = 1'b0, halt = 1'b0;
  logic step = 1'b0, resume = 1'b0, flush = 1'b0;
  logic pc_we, ifid_we, ifid_fl, idex_fl, gstall, gflush, halted;
  logic [CW-1:0] stall_cnt, flush_cnt;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipeline_control_unit #(.CNT_W(CW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .load_use_hazard_i (lu),
    .branch_taken_i    (br),
    .mem_busy_i        (busy),
    .halt_req_i        (halt),
    .step_req_i        (step),
    .resume_req_i      (resume),
    .flush_req_i       (flush),
    .pc_write_en_o     (pc_we),
    .if_id_write_en_o  (ifid_we),
    .if_id_flush_o     (ifid_fl),
    .id_ex_flush_o     (idex_fl),
    .global_stall_o    (gstall),
    .global_flush_o    (gflush),
    .halted_o          (halted),
    .stall_cycles_o    (stall_cnt),
    .flush_count_o     (flush_cnt)
  );

  // Monitor: every cycle with a pending expectation is checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e   = sb.pop_front();
      act = {pc_we, ifid_we, ifid_fl, idex_fl, gstall, gflush, halted};
      total++;
      if (((act ^ e.exp) & e.mask) != 7'd0) begin
        bad++;
        $display("FAIL %s: outputs got %b want %b (mask %b)", e.name, act, e.exp, e.mask);
      end
      if (e.chk_cnt) begin
        total++;
        if (stall_cnt !== e.exp_stall || flush_cnt !== e.exp_flush) begin
          bad++;
          $display("FAIL %s: counters got stall=%0d flush=%0d want stall=%0d flush=%0d",
                   e.name, stall_cnt, flush_cnt, e.exp_stall, e.exp_flush);
        end
      end
    end
  end

  task automatic cyc(input logic rstv, input logic [6:0] iv, input bit do_chk,
                     input logic [6:0] exp, input logic [6:0] mask, input bit chk_cnt,
                     input logic [CW-1:0] es, input logic [CW-1:0] ef, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rstv;
    {lu, br, busy, halt, step, resume, flush} = iv;
    if (do_chk) begin
      e.exp = exp; e.mask = mask; e.chk_cnt = chk_cnt;
      e.exp_stall = es; e.exp_flush = ef; e.name = nm;
      sb.push_back(e);
    end
  endtask

  task automatic chk(input logic [6:0] iv, input logic [6:0] exp, input logic [6:0] mask,
                     input string nm);
    cyc(1'b1, iv, 1'b1, exp, mask, 1'b0, '0, '0, nm);
  endtask

  initial begin
    cyc(1'b0, I_NONE, 1'b1, E_RUN, M_ALL, 1'b1, '0, '0, "reset_state");
    chk(I_NONE, E_RUN, M_ALL, "idle_after_reset");
    chk(I_LU, E_LU, M_ALL, "load_use_bubble");
    chk(I_NONE, E_RUN, M_ALL, "after_bubble");
    chk(I_BR | I_LU, E_BR, M_ALL, "branch_over_loaduse");
    chk(I_LU | I_BUSY, E_BUSY, M_STALL, "loaduse_under_stall");
    chk(I_BR | I_BUSY, E_BUSY, M_STALL, "branch_under_stall");

    // Halt held off by a busy memory, taken once it drops.
    chk(I_HALT | I_BUSY, E_BUSY, M_STALL, "halt_busy_c1");
    chk(I_BUSY, E_BUSY, M_STALL, "halt_busy_c2");
    chk(I_BUSY, E_BUSY, M_STALL, "halt_busy_c3");
    chk(I_NONE, E_RUN, M_ALL, "busy_dropped");
    chk(I_NONE, E_HALT, M_STALL, "halted_after_busy");

    // Single step, plain and memory-extended.
    chk(I_STEP, E_HALT, M_STALL, "step_req");
    chk(I_NONE, E_RUN, M_ALL, "step_cycle");
    chk(I_NONE, E_HALT, M_STALL, "back_to_halt");
    chk(I_STEP, E_HALT, M_STALL, "step_req_busy");
    chk(I_BUSY, E_BUSY, M_STALL, "step_extended");
    chk(I_NONE, E_RUN, M_ALL, "step_busy_drop");
    chk(I_NONE, E_HALT, M_STALL, "back_to_halt2");

    chk(I_STEP | I_RES, E_HALT, M_STALL, "step_and_resume");
    chk(I_NONE, E_RUN, M_ALL, "resume_wins");

    // Debug flush from a fresh reset so counters are predictable.
    cyc(1'b0, I_NONE, 1'b0, '0, '0, 1'b0, '0, '0, "");
    chk(I_HALT, E_RUN, M_ALL, "halt_req_run");
    chk(I_FL, E_HALT, M_STALL, "flush_req_halted");
    chk(I_NONE, E_GFL, M_STALL, "global_flush_pulse");
    cyc(1'b1, I_NONE, 1'b1, E_HALT, M_STALL, 1'b1,
        PERF ? CW'(2) : CW'(0), PERF ? CW'(1) : CW'(0), "flush_pulse_end");

    chk(I_RES, E_HALT, M_STALL, "resume_req");
    chk(I_FL, E_RUN, M_ALL, "flush_req_in_run");
    chk(I_NONE, E_RUN, M_ALL, "flush_ignored_run");

    chk(I_HALT | I_BR, E_BR, M_ALL, "halt_with_branch");
    chk(I_NONE, E_HALT, M_STALL, "halted_after_branch");

    chk(I_STEP, E_HALT, M_STALL, "step_before_reset");
    cyc(1'b0, I_NONE, 1'b1, E_RUN, M_ALL, 1'b1, '0, '0, "reset_mid_step");

    // Stall counter must stick at all-ones.
    chk(I_HALT, E_RUN, M_ALL, "halt_for_sat");
    for (int i = 0; i < 20; i++) cyc(1'b1, I_NONE, 1'b0, '0, '0, 1'b0, '0, '0, "");
    cyc(1'b1, I_NONE, 1'b1, E_HALT, M_STALL, 1'b1,
        PERF ? {CW{1'b1}} : CW'(0), CW'(0), "stall_saturate");

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: left=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
